// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake with a 2-entry skid buffer, flush on redirect,
// and fixed-field decode of the head entry.
module ifid_pipe_reg #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OPC_W = 4,
    parameter int unsigned REG_W = 4,
    parameter int unsigned FUNCT_W = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INSTR_W-1:0]       instr_in,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_W-1:0]       instr_out,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [ADDR_W-1:0]        addr_next,
    output logic [OPC_W-1:0]         opcode,
    output logic [REG_W-1:0]         fop1,
    output logic [REG_W-1:0]         fop2,
    output logic [FUNCT_W-1:0]       funct,
    output logic [INSTR_W-OPC_W-1:0] offset,
    output logic [1:0]               occupancy
);

    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  main_addr_q, main_addr_d;
    logic [ADDR_W-1:0]  skid_addr_q, skid_addr_d;
    logic               in_fire, out_fire;

    // in_ready is a function of registers and flush only; out_ready never reaches it.
    assign in_ready  = ~skid_valid_q & ~flush;
    assign out_valid = main_valid_q & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_instr_d = main_instr_q;
        main_addr_d  = main_addr_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_fire && skid_valid_q) begin
            main_instr_d = skid_instr_q;
            main_addr_d  = skid_addr_q;
            skid_valid_d = 1'b0;
        end else if (in_fire && (!main_valid_q || out_fire)) begin
            main_instr_d = instr_in;
            main_addr_d  = addr_in;
            main_valid_d = 1'b1;
        end else if (in_fire) begin
            skid_instr_d = instr_in;
            skid_addr_d  = addr_in;
            skid_valid_d = 1'b1;
        end else if (out_fire) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_instr_q <= '0;
            main_addr_q  <= '0;
            skid_instr_q <= '0;
            skid_addr_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_instr_q <= main_instr_d;
            main_addr_q  <= main_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
        end
    end

    assign instr_out = out_valid ? main_instr_q : NOP_INSTR;
    assign addr_out  = out_valid ? main_addr_q : '0;
    assign addr_next = addr_out + 1'b1;
    assign opcode    = instr_out[INSTR_W-1 -: OPC_W];
    assign fop1      = instr_out[INSTR_W-OPC_W-1 -: REG_W];
    assign fop2      = instr_out[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign funct     = instr_out[FUNCT_W-1:0];
    assign offset    = instr_out[INSTR_W-OPC_W-1:0];
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule
